// File: rtl/tile_renderer.sv
// tile_renderer: fetches one tile's map entry, color attribute, pattern row and two palette
// entries per 16-clock slot, then emits pixel-doubled RGB332 with sync, all 17 clocks late.
module tile_renderer #(
  parameter logic [11:0] COLOR_ATTR_BASE = 12'h800,
  parameter logic [7:0]  BLANK_COLOR     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        visible_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] tile_memory_read_addr,
  input  logic [7:0]  tile_memory_read_data,
  output logic [11:0] attribute_memory_read_addr,
  input  logic [7:0]  attribute_memory_read_data,
  output logic [3:0]  color_memory_read_addr,
  input  logic [7:0]  color_memory_read_data,
  output logic [7:0]  rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        visible_out
);
  localparam int LATENCY = 17;
  logic [3:0] ph;
  logic [10:0] map_addr;
  logic [7:0] idx, cattr, pattern, fg, bg, disp_pattern, disp_fg, disp_bg;
  logic slot_ok, disp_ok;
  logic [LATENCY-1:0] vis_sr, hs_sr, vs_sr;
  logic unused;
  assign ph = pixel_x[3:0];
  assign map_addr = {pixel_y[8:4], pixel_x[9:4]};
  assign unused = pixel_y[9];
  assign visible_out = vis_sr[LATENCY-1];
  assign hsync_out = hs_sr[LATENCY-1];
  assign vsync_out = vs_sr[LATENCY-1];
  // slot_ok marks a slot whose whole fetch ran out of reset; a slot cut by reset displays as blank
  always_ff @(posedge clk)
    if (!rst) begin
      {vis_sr, hs_sr, vs_sr} <= '0;
      {rgb_out, tile_memory_read_addr, attribute_memory_read_addr, color_memory_read_addr} <= '0;
      {idx, cattr, pattern, fg, bg, disp_pattern, disp_fg, disp_bg} <= '0;
      {slot_ok, disp_ok} <= '0;
    end else begin
      vis_sr <= {vis_sr[LATENCY-2:0], visible_in};
      hs_sr <= {hs_sr[LATENCY-2:0], hsync_in};
      vs_sr <= {vs_sr[LATENCY-2:0], vsync_in};
      rgb_out <= (vis_sr[LATENCY-2] && disp_ok) ? (disp_pattern[~ph[3:1]] ? disp_fg : disp_bg) : BLANK_COLOR;
      case (ph)
        4'd0: begin
          attribute_memory_read_addr <= {1'b0, map_addr};
          slot_ok <= 1'b1;
        end
        4'd1: begin
          idx <= attribute_memory_read_data;
          attribute_memory_read_addr <= COLOR_ATTR_BASE | {1'b0, map_addr};
        end
        4'd2: begin
          cattr <= attribute_memory_read_data;
          tile_memory_read_addr <= {idx, pixel_y[3:1]};
        end
        4'd3: begin
          pattern <= tile_memory_read_data;
          color_memory_read_addr <= cattr[7:4];
        end
        4'd4: begin
          fg <= color_memory_read_data;
          color_memory_read_addr <= cattr[3:0];
        end
        4'd5: bg <= color_memory_read_data;
        4'd15: begin
          disp_pattern <= pattern;
          disp_fg <= fg;
          disp_bg <= bg;
          disp_ok <= slot_ok;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: drives raster vectors, records every input cycle and checks outputs
// against a pixel model derived from the tile/attribute/palette rules, plus literal pins.
module tb_tile_renderer;
  localparam int N = 8192;
  logic clk = 1'b0, rst = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic visible_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [10:0] tile_memory_read_addr;
  logic [11:0] attribute_memory_read_addr;
  logic [3:0] color_memory_read_addr;
  logic [7:0] tile_memory_read_data, attribute_memory_read_data, color_memory_read_data, rgb_out;
  logic hsync_out, vsync_out, visible_out;
  logic [7:0] tile_mem [2048];
  logic [7:0] attr_mem [4096];
  logic [7:0] color_mem [16];
  logic [9:0] hx [N];
  logic [9:0] hy [N];
  bit hv [N], hh [N], hvs [N], hr [N];
  logic [7:0] lit [16];
  logic [127:0] lit_vec;
  bit lit_on = 1'b0;
  int lit_base = 0, pe = 0, total = 0, bad = 0;

  tile_renderer dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .visible_in(visible_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .tile_memory_read_addr(tile_memory_read_addr), .tile_memory_read_data(tile_memory_read_data),
    .attribute_memory_read_addr(attribute_memory_read_addr), .attribute_memory_read_data(attribute_memory_read_data),
    .color_memory_read_addr(color_memory_read_addr), .color_memory_read_data(color_memory_read_data),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .visible_out(visible_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pe <= pe + 1;
  assign tile_memory_read_data = tile_mem[tile_memory_read_addr];
  assign attribute_memory_read_data = attr_mem[attribute_memory_read_addr];
  assign color_memory_read_data = color_mem[color_memory_read_addr];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, pe - 1, act, exp);
    end
  endtask

  task automatic step(input int x, input int y, input bit r);
    if (pe >= N) begin
      $display("FAIL cycle_budget edge=%0d got=%0d expected=%0d", pe, pe, N - 1);
      $fatal(1);
    end
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    visible_in = x < 640 && y < 480;
    hsync_in = !(x >= 656 && x < 752);
    vsync_in = !(y >= 490 && y < 492);
    rst = r;
    hx[pe] = pixel_x; hy[pe] = pixel_y; hv[pe] = visible_in;
    hh[pe] = hsync_in; hvs[pe] = vsync_in; hr[pe] = r;
    @(negedge clk);
  endtask

  task automatic set_lit(input logic [127:0] v);
    lit_vec = v;
    for (int i = 0; i < 16; i++) lit[i] = lit_vec[127 - 8*i -: 8];
    lit_base = pe;
    lit_on = 1'b1;
  endtask

  // pixel colour straight from map -> attribute -> pattern -> palette for the pixel at (x,y)
  function automatic logic [7:0] model_pix(input int n);
    logic [10:0] a;
    logic [7:0] ca, pat;
    a = {hy[n][8:4], hx[n][9:4]};
    ca = attr_mem[12'h800 | {1'b0, a}];
    pat = tile_mem[{attr_mem[{1'b0, a}], hy[n][3:1]}];
    return pat[7 - int'(hx[n][3:1])] ? color_mem[ca[7:4]] : color_mem[ca[3:0]];
  endfunction

  always @(negedge clk) begin : cmp
    int m, n, s;
    bit rz, rs, cont;
    if (pe > 0) begin
      m = pe - 1;
      if (!hr[m]) begin
        chk("rst_rgb", rgb_out, 0);
        chk("rst_attr_addr", attribute_memory_read_addr, 0);
        chk("rst_tile_addr", tile_memory_read_addr, 0);
        chk("rst_color_addr", color_memory_read_addr, 0);
      end
      if (m >= 16) begin
        n = m - 16;
        rz = 1'b0;
        for (int k = n; k <= m; k++) if (!hr[k]) rz = 1'b1;
        chk("visible_out", visible_out, rz ? 0 : int'(hv[n]));
        chk("hsync_out", hsync_out, rz ? 0 : int'(hh[n]));
        chk("vsync_out", vsync_out, rz ? 0 : int'(hvs[n]));
        s = n - int'(hx[n][3:0]);
        cont = s >= 0;
        rs = 1'b0;
        if (cont)
          for (int k = s; k <= m; k++) begin
            if (!hr[k]) rs = 1'b1;
            if (k > s && int'(hx[k]) != (int'(hx[k-1]) + 1) % 800) cont = 1'b0;
          end
        if (rz || !hv[n]) chk("rgb_blank", rgb_out, 0);
        else if (cont && rs) chk("rgb_after_reset", rgb_out, 0);
        else if (cont) chk("rgb_pixel", rgb_out, model_pix(n));
        if (lit_on && n >= lit_base && n < lit_base + 16) chk("rgb_literal", rgb_out, lit[n - lit_base]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) tile_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) attr_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) color_mem[i] = 8'($urandom) | 8'h01;
    attr_mem[12'h000] = 8'h41; attr_mem[12'h800] = 8'h25; tile_mem[11'h208] = 8'hA5;
    color_mem[2] = 8'hE0; color_mem[5] = 8'h03;
    attr_mem[12'h082] = 8'h9C; attr_mem[12'h882] = 8'h7B;
    attr_mem[12'h767] = 8'h33; attr_mem[12'hF67] = 8'hC4; tile_mem[11'h19F] = 8'h3C;
    color_mem[12] = 8'h1F; color_mem[4] = 8'hFC;
    for (int i = 0; i < 10; i++) step($urandom_range(0, 799), $urandom_range(0, 524), 1'b0);
    set_lit(128'hE0E00303E0E00303_0303E0E00303E0E0);
    for (int x = 0; x < 48; x++) step(x, 0, 1'b1);
    step(32, 35, 1'b1); chk("attr_addr_ph0", attribute_memory_read_addr, 12'h082);
    step(33, 35, 1'b1); chk("attr_addr_ph1", attribute_memory_read_addr, 12'h882);
    step(34, 35, 1'b1); chk("tile_addr_ph2", tile_memory_read_addr, 11'h4E1);
    step(35, 35, 1'b1); chk("color_addr_fg", color_memory_read_addr, 4'h7);
    step(36, 35, 1'b1); chk("color_addr_bg", color_memory_read_addr, 4'hB);
    for (int x = 37; x < 261; x++) step(x, 35, x != 100);
    for (int x = 600; x < 624; x++) step(x, 479, 1'b1);
    set_lit(128'hFCFCFCFC1F1F1F1F_1F1F1F1FFCFCFCFC);
    step(624, 479, 1'b1); chk("attr_addr_edge_map", attribute_memory_read_addr, 12'h767);
    step(625, 479, 1'b1); chk("attr_addr_edge_attr", attribute_memory_read_addr, 12'hF67);
    for (int x = 626; x < 800; x++) step(x, 479, 1'b1);
    for (int j = 0; j < 6; j++) begin
      int x0, y0;
      x0 = $urandom_range(0, 700);
      y0 = $urandom_range(0, 479);
      for (int x = x0; x < x0 + 64; x++) step(x % 800, y0, 1'b1);
    end
    for (int x = 0; x < 121; x++) step(x, 490, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
